// File: rtl/wtc_pkg.sv
// Shared types and constants for the window transaction checker.
package wtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_VERDICT = 2'd2
  } wtc_state_e;

  localparam int FAIL_CODE_W = 4;
  localparam int FC_WR_CNT   = 0;
  localparam int FC_RD_CNT   = 1;
  localparam int FC_SHORT_RD = 2;
  localparam int FC_TIMEOUT  = 3;

endpackage

// File: rtl/window_txn_checker_if.sv
// Bus-side bundle of the window checker: window control, per-channel strobes and the verdict.
interface window_txn_checker_if #(parameter int NCH = 4);
  logic                            start;
  logic                            stop;
  logic [NCH-1:0]                  wr;
  logic [NCH-1:0]                  rd;
  logic                            win_open;
  logic                            pass;
  logic                            fail;
  logic [wtc_pkg::FAIL_CODE_W-1:0] fail_code;
  logic [NCH-1:0]                  fail_ch;

  modport master (output start, stop, wr, rd,
                  input  win_open, pass, fail, fail_code, fail_ch);
  modport slave  (input  start, stop, wr, rd,
                  output win_open, pass, fail, fail_code, fail_ch);
endinterface

// File: rtl/wtc_chan.sv
// Per-channel tracker: write count, read-run detection, completed-read count and short-read flag.
// Mismatch flags are taken from next-state values so the top can register the verdict on the closing edge.
module wtc_chan #(
  parameter int RD_LAT = 2,
  parameter int WR_REQ = 1,
  parameter int RD_REQ = 1,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic wr,
  input  logic rd,
  output logic wr_bad,
  output logic rd_bad,
  output logic short_rd
);
  localparam int                RUN_W    = $clog2(RD_LAT + 1);
  localparam logic [RUN_W-1:0]  RUN_FULL = RUN_W'(RD_LAT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, wr_base_s;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, rd_base_s;
  logic [RUN_W-1:0] run_q, run_d, run_base_s;
  logic             short_q, short_d, short_base_s;

  // Opening a window starts from zero but still samples the opening cycle.
  always_comb begin
    if (clr) begin
      wr_base_s    = {CNT_W{1'b0}};
      rd_base_s    = {CNT_W{1'b0}};
      run_base_s   = {RUN_W{1'b0}};
      short_base_s = 1'b0;
    end else begin
      wr_base_s    = wr_cnt_q;
      rd_base_s    = rd_cnt_q;
      run_base_s   = run_q;
      short_base_s = short_q;
    end
    wr_cnt_d = wr_base_s;
    rd_cnt_d = rd_base_s;
    run_d    = run_base_s;
    short_d  = short_base_s;
    if (en) begin
      if (wr && (wr_base_s != CNT_MAX)) begin
        wr_cnt_d = wr_base_s + 1'b1;
      end else begin
        wr_cnt_d = wr_base_s;
      end
      if (rd) begin
        if (run_base_s != RUN_FULL) begin
          run_d = run_base_s + 1'b1;
          if ((run_d == RUN_FULL) && (rd_base_s != CNT_MAX)) begin
            rd_cnt_d = rd_base_s + 1'b1;
          end else begin
            rd_cnt_d = rd_base_s;
          end
        end else begin
          run_d = run_base_s;
        end
      end else begin
        run_d   = {RUN_W{1'b0}};
        short_d = short_base_s | ((run_base_s != {RUN_W{1'b0}}) && (run_base_s != RUN_FULL));
      end
    end else begin
      run_d = run_base_s;
    end
  end

  assign wr_bad   = (wr_cnt_d != CNT_W'(WR_REQ));
  assign rd_bad   = (rd_cnt_d != CNT_W'(RD_REQ));
  assign short_rd = short_d;

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= {CNT_W{1'b0}};
      rd_cnt_q <= {CNT_W{1'b0}};
      run_q    <= {RUN_W{1'b0}};
      short_q  <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      run_q    <= run_d;
      short_q  <= short_d;
    end
  end
endmodule

// File: rtl/window_txn_checker.sv
// Multi-channel transaction-window checker: window FSM, rise detect, verdict reduction.
// Optional window timeout is built when WTC_TIMEOUT_EN is defined.
module window_txn_checker
  import wtc_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int RD_LAT  = 2,
  parameter int WR_REQ  = 1,
  parameter int RD_REQ  = 1,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  window_txn_checker_if.slave  bus
);
  wtc_state_e             state_q, state_d;
  logic                   start_q;
  logic                   win_open_q, win_open_d;
  logic                   pass_q, pass_d;
  logic                   fail_q, fail_d;
  logic [FAIL_CODE_W-1:0] fail_code_q, fail_code_d, code_s;
  logic [NCH-1:0]         fail_ch_q, fail_ch_d;
  logic [NCH-1:0]         wr_bad_s, rd_bad_s, short_s;
  logic                   rise_s, open_s, in_win_s, to_s, close_s, to_only_s;

  assign rise_s    = bus.start & ~start_q;
  assign open_s    = (state_q == ST_IDLE) & rise_s;
  assign in_win_s  = open_s | (state_q == ST_OPEN);
  assign close_s   = in_win_s & (bus.stop | to_s);
  assign to_only_s = to_s & ~bus.stop;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    wtc_chan #(
      .RD_LAT (RD_LAT),
      .WR_REQ (WR_REQ),
      .RD_REQ (RD_REQ),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .clr      (open_s),
      .en       (in_win_s),
      .wr       (bus.wr[g]),
      .rd       (bus.rd[g]),
      .wr_bad   (wr_bad_s[g]),
      .rd_bad   (rd_bad_s[g]),
      .short_rd (short_s[g])
    );
  end

`ifdef WTC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] win_cnt_q, win_cnt_d, cyc_s;

  // Window length including the current cycle; the opening cycle is cycle 1.
  always_comb begin
    if (open_s) begin
      cyc_s = TO_W'(1);
    end else begin
      cyc_s = win_cnt_q + 1'b1;
    end
    if (in_win_s) begin
      win_cnt_d = cyc_s;
    end else begin
      win_cnt_d = win_cnt_q;
    end
    to_s = in_win_s & (cyc_s >= TO_W'(TIMEOUT));
  end

  // Window length register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q <= {TO_W{1'b0}};
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end
`else
  // Without the counter a window never times out; TIMEOUT is referenced only to keep the parameter used.
  assign to_s = (TIMEOUT < 0);
`endif

  // Next state and the verdict that becomes visible during the VERDICT cycle.
  always_comb begin
    code_s = {FAIL_CODE_W{1'b0}};
    if (to_only_s) begin
      code_s[FC_TIMEOUT] = 1'b1;
    end else begin
      code_s[FC_WR_CNT]   = |wr_bad_s;
      code_s[FC_RD_CNT]   = |rd_bad_s;
      code_s[FC_SHORT_RD] = |short_s;
    end
    case (state_q)
      ST_IDLE: begin
        if (open_s) begin
          if (bus.stop || to_s) begin
            state_d = ST_VERDICT;
          end else begin
            state_d = ST_OPEN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (bus.stop || to_s) begin
          state_d = ST_VERDICT;
        end else begin
          state_d = ST_OPEN;
        end
      end
      ST_VERDICT: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    win_open_d = (state_d == ST_OPEN);
    pass_d     = close_s & (code_s == {FAIL_CODE_W{1'b0}});
    fail_d     = close_s & (code_s != {FAIL_CODE_W{1'b0}});
    if (fail_d && !to_only_s) begin
      fail_code_d = code_s;
      fail_ch_d   = wr_bad_s | rd_bad_s | short_s;
    end else if (fail_d) begin
      fail_code_d = code_s;
      fail_ch_d   = {NCH{1'b0}};
    end else begin
      fail_code_d = {FAIL_CODE_W{1'b0}};
      fail_ch_d   = {NCH{1'b0}};
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      win_open_q  <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= {FAIL_CODE_W{1'b0}};
      fail_ch_q   <= {NCH{1'b0}};
    end else begin
      state_q     <= state_d;
      start_q     <= bus.start;
      win_open_q  <= win_open_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_code_q <= fail_code_d;
      fail_ch_q   <= fail_ch_d;
    end
  end

  assign bus.win_open  = win_open_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.fail_code = fail_code_q;
  assign bus.fail_ch   = fail_ch_q;
endmodule

// File: tb/tb_window_txn_checker.sv
// Bench for window_txn_checker: directed scenarios plus random traffic against a window-level reference model.
module tb_window_txn_checker;
  localparam int NCH    = 4;
  localparam int RD_LAT = 2;
  localparam int TB_TO  = 8;
`ifdef WTC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window_txn_checker_if #(.NCH(NCH)) bus ();

  window_txn_checker #(
    .NCH(NCH), .RD_LAT(RD_LAT), .WR_REQ(1), .RD_REQ(1), .CNT_W(4), .TIMEOUT(TB_TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: window membership and the samples seen inside the current window.
  bit          m_open = 1'b0;
  bit          m_verd = 1'b0;
  bit          m_start_q = 1'b0;
  logic [3:0]  q_wr[$];
  logic [3:0]  q_rd[$];
  logic [10:0] exp_vec = 11'd0;
  logic [10:0] got_vec;
  int          n_verd = 0;

  assign got_vec = {bus.win_open, bus.pass, bus.fail, bus.fail_code, bus.fail_ch};

  function automatic void eval_win(input bit to, output logic [3:0] code, output logic [3:0] ch);
    code = 4'd0;
    ch   = 4'd0;
    if (to) begin
      code = 4'b1000;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        int wc, rc, run;
        bit sh;
        wc = 0; rc = 0; run = 0; sh = 1'b0;
        for (int k = 0; k < q_wr.size(); k++) begin
          if (q_wr[k][c]) wc++;
          if (q_rd[k][c]) run++;
          else begin
            if (run > 0 && run < RD_LAT) sh = 1'b1;
            if (run >= RD_LAT) rc++;
            run = 0;
          end
        end
        if (run >= RD_LAT) rc++;
        if (wc > 15) wc = 15;
        if (rc > 15) rc = 15;
        if (wc != 1) begin code[0] = 1'b1; ch[c] = 1'b1; end
        if (rc != 1) begin code[1] = 1'b1; ch[c] = 1'b1; end
        if (sh)      begin code[2] = 1'b1; ch[c] = 1'b1; end
      end
    end
  endfunction

  task automatic model_reset();
    m_open = 1'b0; m_verd = 1'b0; m_start_q = 1'b0;
    q_wr.delete(); q_rd.delete();
    exp_vec = 11'd0;
  endtask

  // Drive one cycle, predict the outputs after the edge, and advance to 1 time unit past the edge.
  task automatic cyc(input logic s, input logic p, input logic [3:0] w, input logic [3:0] r);
    bit rise, opening, in_win, to_hit, closing;
    logic [3:0] code, ch;
    bus.start = s; bus.stop = p; bus.wr = w; bus.rd = r;
    rise    = s && !m_start_q;
    opening = rise && !m_open && !m_verd;
    if (opening) begin q_wr.delete(); q_rd.delete(); end
    in_win  = opening || m_open;
    if (in_win) begin q_wr.push_back(w); q_rd.push_back(r); end
    to_hit  = TO_EN && in_win && !p && (q_wr.size() >= TB_TO);
    closing = in_win && (p || to_hit);
    code = 4'd0; ch = 4'd0;
    if (closing) begin eval_win(to_hit, code, ch); n_verd++; end
    m_verd    = closing;
    m_open    = in_win && !closing;
    m_start_q = s;
    exp_vec   = {m_open, closing && (code == 4'd0), closing && (code != 4'd0), code, ch};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.wr = 4'd0; bus.rd = 4'd0;
    @(posedge clk); #1;
    n_cmp++;
    if (got_vec !== 11'd0) begin
      n_bad++; $display("FAIL reset: got %b want %b", got_vec, 11'd0);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic test_missing_traffic();
    for (int i = 0; i < 22; i++) begin
      cyc(i == 0, i == 18, (i == 1) ? 4'b0001 : 4'd0, (i == 3 || i == 4) ? 4'b0001 : 4'd0);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL missing_traffic i=%0d: got %b want %b", i, got_vec, exp_vec);
      end
`ifndef WTC_TIMEOUT_EN
      if (i == 18) begin
        n_cmp++;
        if ({bus.pass, bus.fail, bus.fail_code, bus.fail_ch} !== {1'b0, 1'b1, 4'b0011, 4'b1110}) begin
          n_bad++; $display("FAIL missing_traffic_verdict: got %b want %b",
                            {bus.pass, bus.fail, bus.fail_code, bus.fail_ch}, {1'b0, 1'b1, 4'b0011, 4'b1110});
        end
      end
`endif
    end
  endtask

  task automatic test_all_pass();
    for (int i = 0; i < 14; i++) begin
      cyc(i == 0, i == 10, (i == 2) ? 4'hF : 4'd0, (i == 4 || i == 5) ? 4'hF : 4'd0);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL all_pass i=%0d: got %b want %b", i, got_vec, exp_vec);
      end
`ifndef WTC_TIMEOUT_EN
      n_cmp++;
      if (bus.pass !== (i == 10)) begin
        n_bad++; $display("FAIL all_pass_pulse i=%0d: got %b want %b", i, bus.pass, (i == 10));
      end
`endif
    end
  endtask

  task automatic test_short_rd();
    logic [3:0] r;
    for (int i = 0; i < 13; i++) begin
      r = (i == 3 || i == 4) ? 4'b1011 : 4'd0;
      r[2] = (i == 2 || i == 4 || i == 5);
      cyc(i == 0, i == 10, (i == 1) ? 4'hF : 4'd0, r);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL short_rd i=%0d: got %b want %b", i, got_vec, exp_vec);
      end
`ifndef WTC_TIMEOUT_EN
      if (i == 10) begin
        n_cmp++;
        if ({bus.fail, bus.fail_code, bus.fail_ch} !== {1'b1, 4'b0100, 4'b0100}) begin
          n_bad++; $display("FAIL short_rd_verdict: got %b want %b",
                            {bus.fail, bus.fail_code, bus.fail_ch}, {1'b1, 4'b0100, 4'b0100});
        end
      end
`endif
    end
  endtask

  task automatic test_same_cycle_and_rerise();
    int v0;
    v0 = n_verd;
    for (int i = 0; i < 13; i++) begin
      cyc(i == 0 || i == 3 || i == 6, i == 0 || i == 9, 4'd0, 4'd0);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL same_cycle i=%0d: got %b want %b", i, got_vec, exp_vec);
      end
      if (i == 0) begin
        n_cmp++;
        if ({bus.fail, bus.fail_code, bus.fail_ch} !== {1'b1, 4'b0011, 4'b1111}) begin
          n_bad++; $display("FAIL same_cycle_verdict: got %b want %b",
                            {bus.fail, bus.fail_code, bus.fail_ch}, {1'b1, 4'b0011, 4'b1111});
        end
      end
    end
    n_cmp++;
    if (n_verd - v0 !== 2) begin
      n_bad++; $display("FAIL rerise_verdict_count: got %0d want %0d", n_verd - v0, 2);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      cyc((i == 0) || (i == 4) || (i == 5) || (i == 7) || (i == 14), (i == 3) || (i == 9) || (i == 15),
          (i == 1) ? 4'hF : 4'd0, (i == 1 || i == 2) ? 4'hF : 4'd0);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL back_to_back i=%0d: got %b want %b", i, got_vec, exp_vec);
      end
    end
    for (int i = 0; i < 8; i++) begin
      cyc((i == 0) || (i == 4), (i == 2) || (i == 5), 4'd0, 4'd0);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL earliest_rise i=%0d: got %b want %b", i, got_vec, exp_vec);
      end
      if (i == 4) begin
        n_cmp++;
        if (bus.win_open !== 1'b1) begin
          n_bad++; $display("FAIL earliest_rise_open: got %b want %b", bus.win_open, 1'b1);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] w, r;
    for (int i = 0; i < 78; i++) begin
      w = (i == 1) ? 4'hF : 4'd0;
      w[0] = (i >= 1 && i <= 17);
      r = (i == 20 || i == 21) ? 4'b1101 : 4'd0;
      r[1] = (i >= 20 && i < 71 && ((i - 20) % 3) != 2);
      cyc(i == 0, i == 75, w, r);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL saturation i=%0d: got %b want %b", i, got_vec, exp_vec);
      end
`ifndef WTC_TIMEOUT_EN
      if (i == 75) begin
        n_cmp++;
        if ({bus.fail, bus.fail_code, bus.fail_ch} !== {1'b1, 4'b0011, 4'b0011}) begin
          n_bad++; $display("FAIL saturation_verdict: got %b want %b",
                            {bus.fail, bus.fail_code, bus.fail_ch}, {1'b1, 4'b0011, 4'b0011});
        end
      end
`endif
    end
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < 4; i++) cyc(i == 0, 1'b0, (i == 1) ? 4'hF : 4'd0, 4'd0);
    bus.start = 1'b0; bus.stop = 1'b0; bus.wr = 4'd0; bus.rd = 4'd0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (got_vec !== 11'd0) begin
      n_bad++; $display("FAIL reset_mid: got %b want %b", got_vec, 11'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(i == 5, (i == 2) || (i == 11), (i == 6) ? 4'hF : 4'd0, (i == 7 || i == 8) ? 4'hF : 4'd0);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL reset_then_pass i=%0d: got %b want %b", i, got_vec, exp_vec);
      end
    end
  endtask

`ifdef WTC_TIMEOUT_EN
  task automatic test_timeout();
    for (int i = 0; i < 16; i++) begin
      cyc(i == 0, i == 12, 4'd0, 4'd0);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL timeout i=%0d: got %b want %b", i, got_vec, exp_vec);
      end
      if (i == 7) begin
        n_cmp++;
        if ({bus.fail, bus.fail_code, bus.fail_ch} !== {1'b1, 4'b1000, 4'b0000}) begin
          n_bad++; $display("FAIL timeout_verdict: got %b want %b",
                            {bus.fail, bus.fail_code, bus.fail_ch}, {1'b1, 4'b1000, 4'b0000});
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] w, r_lvl, flip;
    r_lvl = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        w[c]    = ($urandom_range(0, 7) == 0);
        flip[c] = ($urandom_range(0, 2) == 0);
      end
      r_lvl = r_lvl ^ flip;
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0, w, r_lvl);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL random i=%0d: got %b want %b", i, got_vec, exp_vec);
      end
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'd0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_missing_traffic();
    test_all_pass();
    test_short_rd();
    test_same_cycle_and_rerise();
    test_back_to_back();
    test_saturation();
    test_reset_mid_window();
`ifdef WTC_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
